// File: rtl/mux_pipeline_hs_if.sv
// Handshake and data bundle for mux_pipeline_hs.
// The slave modport is the mux side; the master modport is the environment side.
interface mux_pipeline_hs_if #(
  parameter int unsigned WIDTH       = 1,
  parameter int unsigned INPUT_COUNT = 2
);
  localparam int unsigned SEL_W = $clog2(INPUT_COUNT);

  logic                         in_valid;
  logic                         in_ready;
  logic [SEL_W-1:0]             sel;
  logic [WIDTH*INPUT_COUNT-1:0] in;
  logic                         out_valid;
  logic                         out_ready;
  logic [WIDTH-1:0]             out;
  logic [SEL_W-1:0]             out_sel;
  logic                         err;

  modport master (
    output in_valid, sel, in, out_ready,
    input  in_ready, out_valid, out, out_sel, err
  );

  modport slave (
    input  in_valid, sel, in, out_ready,
    output in_ready, out_valid, out, out_sel, err
  );
endinterface

// File: rtl/mux_pipeline_hs.sv
// Pipelined RADIX-ary mux tree with valid/ready handshake and bubble collapse.
// Define MUX_PIPELINE_HS_SEL_CHECK_EN to drop out-of-range selects and raise a sticky err.
module mux_pipeline_hs #(
  parameter int unsigned WIDTH       = 1,
  parameter int unsigned INPUT_COUNT = 2,
  parameter int unsigned RADIX       = 2
) (
  input logic              clk,
  input logic              rst_n,
  mux_pipeline_hs_if.slave bus
);
  function automatic int unsigned calc_stages(input int unsigned n, input int unsigned r);
    int unsigned s;
    int unsigned cap;
    s   = 0;
    cap = 1;
    for (int unsigned i = 0; i < 32; i++) begin
      if (cap < n) begin
        cap = cap * r;
        s   = s + 1;
      end
    end
    return (s == 0) ? 1 : s;
  endfunction

  function automatic int unsigned words_at(input int unsigned n, input int unsigned r,
                                           input int unsigned k);
    int unsigned w;
    w = n;
    for (int unsigned i = 0; i < k; i++) w = (w + r - 1) / r;
    return w;
  endfunction

  localparam int unsigned STAGES = calc_stages(INPUT_COUNT, RADIX);
  localparam int unsigned SEL_W  = $clog2(INPUT_COUNT);
  localparam int unsigned LOG_R  = $clog2(RADIX);

  logic              in_ok;
  logic [STAGES:1]   vld_q;
  logic [STAGES:1]   load;
  logic [STAGES:0]   vld_at;
  logic [SEL_W-1:0]  sel_q  [1:STAGES];
  logic [SEL_W-1:0]  sel_at [STAGES+1];
  logic              full;

  // Stage k may load unless it and every stage after it is full while out_ready is low;
  // written as a running AND so the ready chain has no self-referencing vector.
  always_comb begin
    load = '0;
    full = 1'b1;
    for (int unsigned k = STAGES; k >= 1; k--) begin
      full    = full & vld_q[k];
      load[k] = bus.out_ready | ~full;
    end
  end

  always_comb begin
    vld_at[0] = in_ok;
    sel_at[0] = bus.sel;
    for (int unsigned k = 1; k <= STAGES; k++) begin
      vld_at[k] = vld_q[k];
      sel_at[k] = sel_q[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int unsigned k = 1; k <= STAGES; k++) sel_q[k] <= '0;
    end else begin
      for (int unsigned k = 1; k <= STAGES; k++) begin
        if (load[k]) begin
          vld_q[k] <= vld_at[k-1];
          sel_q[k] <= sel_at[k-1];
        end
      end
    end
  end

  for (genvar g = 1; g <= STAGES; g++) begin : g_stage
    localparam int unsigned N_PREV = words_at(INPUT_COUNT, RADIX, g - 1);
    localparam int unsigned N_CUR  = words_at(INPUT_COUNT, RADIX, g);
    localparam int unsigned N_PAD  = N_CUR * RADIX;

    logic [WIDTH*N_PREV-1:0] src;
    logic [WIDTH*N_PAD-1:0]  src_pad;
    logic [LOG_R-1:0]        digit;
    logic [WIDTH*N_CUR-1:0]  pick;
    logic [WIDTH*N_CUR-1:0]  data_q;

    if (g == 1) begin : g_head
      assign src = bus.in;
    end else begin : g_body
      assign src = g_stage[g-1].data_q;
    end

    // Zero-extension supplies the missing tree inputs.
    assign src_pad = (WIDTH*N_PAD)'(src);
    assign digit   = LOG_R'(sel_at[g-1] >> (LOG_R * (g - 1)));

    always_comb begin
      pick = '0;
      for (int unsigned j = 0; j < N_CUR; j++) begin
        for (int unsigned r = 0; r < RADIX; r++) begin
          if (digit == LOG_R'(r)) pick[j*WIDTH +: WIDTH] = src_pad[(j*RADIX + r)*WIDTH +: WIDTH];
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       data_q <= '0;
      else if (load[g]) data_q <= pick;
    end
  end

`ifdef MUX_PIPELINE_HS_SEL_CHECK_EN
  logic sel_bad;
  logic err_q;

  assign sel_bad = 32'(bus.sel) >= INPUT_COUNT;
  assign in_ok   = bus.in_valid & ~sel_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  err_q <= 1'b0;
    else if (bus.in_valid && load[1] && sel_bad) err_q <= 1'b1;
  end

  assign bus.err = err_q;
`else
  assign in_ok   = bus.in_valid;
  assign bus.err = 1'b0;
`endif

  assign bus.in_ready  = load[1];
  assign bus.out_valid = vld_at[STAGES];
  assign bus.out_sel   = sel_at[STAGES];
  assign bus.out       = g_stage[STAGES].data_q;
endmodule

// File: tb/tb_mux_pipeline_hs.sv
// Self-checking bench for mux_pipeline_hs: table-driven streaming, backpressure, bubbles,
// mid-stream reset, out-of-range select and a parameter sweep.
module tb_mux_pipeline_hs;
  localparam int unsigned ST_MAIN   = 3;
  localparam int unsigned SW_IC [4] = '{2, 3, 8, 17};
  localparam int unsigned SW_RX [4] = '{2, 4, 2, 4};
  localparam int unsigned SW_ST [4] = '{1, 1, 3, 3};

  typedef struct {
    logic [2:0] sel;
    logic [7:0] exp;
  } vec_t;

  typedef struct {
    logic [7:0]  data;
    logic [2:0]  sel;
    int unsigned due;
  } sb_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  int unsigned cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mux_pipeline_hs_if #(.WIDTH(8), .INPUT_COUNT(5)) bus ();
  mux_pipeline_hs #(.WIDTH(8), .INPUT_COUNT(5), .RADIX(2)) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  logic [3:0]      sw_valid = '0;
  logic [4:0]      sw_sel   = '0;
  logic [3:0]      sw_ov, sw_rdy, sw_err;
  logic [3:0][7:0] sw_out;
  logic [3:0][4:0] sw_osel;

  for (genvar c = 0; c < 4; c++) begin : g_sweep
    localparam int unsigned IC = SW_IC[c];
    localparam int unsigned SW = $clog2(IC);
    mux_pipeline_hs_if #(.WIDTH(8), .INPUT_COUNT(IC)) sif ();
    mux_pipeline_hs #(.WIDTH(8), .INPUT_COUNT(IC), .RADIX(SW_RX[c])) u_dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (sif)
    );
    for (genvar i = 0; i < IC; i++) begin : g_word
      assign sif.in[i*8 +: 8] = 8'(16 + i);
    end
    assign sif.in_valid  = sw_valid[c];
    assign sif.sel       = SW'(sw_sel);
    assign sif.out_ready = 1'b1;
    assign sw_ov[c]      = sif.out_valid;
    assign sw_rdy[c]     = sif.in_ready;
    assign sw_err[c]     = sif.err;
    assign sw_out[c]     = sif.out;
    assign sw_osel[c]    = 5'(sif.out_sel);
  end

  int          checks   = 0;
  int          failures = 0;
  sb_t         scb[$];
  vec_t        vecs[6];
  logic        hold_v = 1'b0;
  logic [7:0]  hold_out;
  logic [2:0]  hold_sel;
  logic [7:0]  cur_exp;
  logic        cur_push, cur_lat;
  logic        accepted;
  logic        exp_err = 1'b0;
  logic        rand_ready = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Negedge half of a cycle: output scoreboard, hold/err checks, input acceptance.
  task automatic tick_neg();
    sb_t e;
    @(negedge clk);
    if (rst_n) begin
      check("err", 32'(bus.err), 32'(exp_err));
      if (hold_v) begin
        check("hold_valid", 32'(bus.out_valid), 32'd1);
        check("hold_out", 32'(bus.out), 32'(hold_out));
        check("hold_sel", 32'(bus.out_sel), 32'(hold_sel));
      end
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (scb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_out actual=%0h required=none (cycle %0d)", bus.out, cyc);
        end else begin
          e = scb.pop_front();
          check("out_data", 32'(bus.out), 32'(e.data));
          check("out_sel", 32'(bus.out_sel), 32'(e.sel));
          if (e.due != 0) check("latency", cyc, e.due);
        end
      end
      hold_v   = bus.out_valid && !bus.out_ready;
      hold_out = bus.out;
      hold_sel = bus.out_sel;
      if (bus.in_valid && bus.in_ready) begin
        accepted = 1'b1;
        if (cur_push) scb.push_back('{data: cur_exp, sel: bus.sel, due: cur_lat ? cyc + ST_MAIN : 0});
`ifdef MUX_PIPELINE_HS_SEL_CHECK_EN
        if (bus.sel >= 3'd5) exp_err = 1'b1;
`endif
      end
    end
  endtask

  task automatic tick_pos();
    @(posedge clk);
    #1;
    if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic tick();
    tick_neg();
    tick_pos();
  endtask

  task automatic send(input logic [2:0] s, input logic [7:0] e, input logic lat);
    bus.in_valid = 1'b1;
    bus.sel      = s;
    cur_exp      = e;
    cur_lat      = lat;
    cur_push     = 1'b1;
`ifdef MUX_PIPELINE_HS_SEL_CHECK_EN
    if (s >= 3'd5) cur_push = 1'b0;
`endif
    accepted = 1'b0;
    for (int unsigned w = 0; w < 64 && !accepted; w++) tick();
    check("send_accept", 32'(accepted), 32'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input int unsigned bound);
    for (int unsigned w = 0; w < bound && (scb.size() != 0 || bus.out_valid); w++) tick();
    check("drain_empty", scb.size(), 0);
  endtask

  initial begin
    vecs[0] = '{3'd0, 8'h10};
    vecs[1] = '{3'd1, 8'h11};
    vecs[2] = '{3'd2, 8'h12};
    vecs[3] = '{3'd3, 8'h13};
    vecs[4] = '{3'd4, 8'h14};
    vecs[5] = '{3'd6, 8'h00};

    bus.in_valid  = 1'b0;
    bus.sel       = '0;
    bus.in        = {8'h14, 8'h13, 8'h12, 8'h11, 8'h10};
    bus.out_ready = 1'b1;
    cur_push      = 1'b0;
    cur_lat       = 1'b0;
    cur_exp       = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out", 32'(bus.out), 32'd0);
    check("rst_out_sel", 32'(bus.out_sel), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    rst_n = 1'b1;

    // Back-to-back stream from the vector table, including an out-of-range select.
    for (int unsigned i = 0; i < 6; i++) send(vecs[i].sel, vecs[i].exp, 1'b1);
    drain(20);

    // Backpressure: three fill the pipeline, the fourth must wait.
    bus.out_ready = 1'b0;
    send(3'd4, 8'h14, 1'b0);
    send(3'd1, 8'h11, 1'b0);
    send(3'd2, 8'h12, 1'b0);
    bus.in_valid = 1'b1;
    bus.sel      = 3'd3;
    cur_exp      = 8'h13;
    cur_push     = 1'b1;
    cur_lat      = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      tick_neg();
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
      check("bp_out", 32'(bus.out), 32'h14);
      check("bp_out_sel", 32'(bus.out_sel), 32'd4);
      tick_pos();
    end
    bus.out_ready = 1'b1;
    send(3'd3, 8'h13, 1'b0);
    drain(20);

    // Bubbles with random downstream readiness.
    rand_ready = 1'b1;
    for (int unsigned n = 0; n < 24; n++) begin
      logic [2:0] s;
      s = 3'($urandom_range(0, 4));
      send(s, 8'h10 + 8'(s), 1'b0);
      tick();
    end
    rand_ready    = 1'b0;
    bus.out_ready = 1'b1;
    drain(40);

    // Asynchronous reset with three transactions in flight.
    bus.out_ready = 1'b0;
    send(3'd0, 8'h10, 1'b0);
    send(3'd2, 8'h12, 1'b0);
    send(3'd4, 8'h14, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_err", 32'(bus.err), 32'd0);
    check("mid_rst_out", 32'(bus.out), 32'd0);
    scb.delete();
    hold_v  = 1'b0;
    exp_err = 1'b0;
    tick();
    tick();
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    tick_neg();
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    tick_pos();
    for (int unsigned i = 0; i < 5; i++) begin
      tick_neg();
      check("no_stale_out", 32'(bus.out_valid), 32'd0);
      tick_pos();
    end

    // Parameter sweep: exact latency and every select value at full rate.
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned t = 0; t < SW_IC[c] + SW_ST[c] + 1; t++) begin
        sw_valid[c] = (t < SW_IC[c]);
        sw_sel      = 5'(t);
        @(negedge clk);
        check("sw_in_ready", 32'(sw_rdy[c]), 32'd1);
        check("sw_err", 32'(sw_err[c]), 32'd0);
        if (t >= SW_ST[c] && t - SW_ST[c] < SW_IC[c]) begin
          check("sw_out_valid", 32'(sw_ov[c]), 32'd1);
          check("sw_out", 32'(sw_out[c]), 32'(16 + t - SW_ST[c]));
          check("sw_out_sel", 32'(sw_osel[c]), t - SW_ST[c]);
        end else begin
          check("sw_idle", 32'(sw_ov[c]), 32'd0);
        end
        @(posedge clk);
        #1;
      end
      sw_valid[c] = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mux_pipeline_hs.md
MUX_PIPELINE_HS -- requirements
Module: mux_pipeline_hs

Interface
REQ-001 The block SHALL have parameter WIDTH, default 1: bits per input word.
REQ-002 The block SHALL have parameter INPUT_COUNT, default 2: number of input words, legal range >=2.
REQ-003 The block SHALL have parameter RADIX, default 2: mux inputs per tree node, power of two, >=2.
REQ-004 The block SHALL define localparam STAGES = ceil(log_RADIX(INPUT_COUNT)) (>=1) and SEL_W = $clog2(INPUT_COUNT).
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL be clocked on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-007 The block SHALL have port in_valid, input, 1 bit: upstream transaction present.
REQ-008 The block SHALL have port in_ready, output, 1 bit: the block accepts a transaction this cycle.
REQ-009 The block SHALL have port sel, input, SEL_W bits: index of the selected word, sampled with in.
REQ-010 The block SHALL have port in, input, WIDTH*INPUT_COUNT bits: word i at in[i*WIDTH+:WIDTH].
REQ-011 The block SHALL have port out_valid, output, 1 bit: result present.
REQ-012 The block SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-013 The block SHALL have port out, output, WIDTH bits: the selected word.
REQ-014 The block SHALL have port out_sel, output, SEL_W bits: the sel that produced out.
REQ-015 The block SHALL have port err, output, 1 bit: sticky out-of-range-select flag (see Configuration).

Function
REQ-016 A transfer SHALL occur on a rising edge with in_valid && in_ready (input) or out_valid && out_ready (output).
REQ-017 The block SHALL hold STAGES register stages; stage k (1..STAGES) SHALL store valid_k, full sel, and ceil(INPUT_COUNT/RADIX^k) candidate words, each the RADIX:1 choice of stage k-1 using sel digit k-1 (base RADIX, LSB digit first); stage 0 is the in port.
REQ-018 Missing tree inputs (INPUT_COUNT not a power of RADIX) SHALL read as zero.
REQ-019 out, out_sel, out_valid SHALL be driven directly from stage STAGES registers; no combinational path from in to out.
REQ-020 Stage k SHALL load when it is empty or its contents advance this cycle; advance of stage STAGES = out_ready; in_ready = load enable of stage 1.
REQ-021 Latency with out_ready held high SHALL be exactly STAGES cycles from input transfer to out_valid; throughput one transfer per cycle.
REQ-022 Empty stages SHALL be filled while downstream stalls (bubble collapse); full occupancy SHALL be STAGES transactions.
REQ-023 With out_valid high and out_ready low, out and out_sel SHALL hold stable until the transfer.
REQ-024 Transactions SHALL leave in acceptance order, none lost or duplicated.
REQ-025 in_ready SHALL not depend combinationally on in_valid.

Reset
REQ-026 On rst_n low all valid_k, out_valid and err SHALL clear to 0 immediately; data, sel registers and out, out_sel SHALL reset to 0.
REQ-027 Transactions in flight at reset SHALL be discarded; in_ready SHALL be 1 from the first edge after rst_n release.

Configuration
REQ-028 Macro MUX_PIPELINE_HS_SEL_CHECK_EN SHALL select out-of-range handling of sel >= INPUT_COUNT.
REQ-029 With MUX_PIPELINE_HS_SEL_CHECK_EN defined, such a transaction SHALL be accepted, dropped (never reaches out_valid), and set err to 1 the edge after acceptance, held until reset.
REQ-030 Without the macro, such a transaction SHALL pass normally with out = 0, and err SHALL be tied 0.

Verification (WIDTH=8, INPUT_COUNT=5, RADIX=2, STAGES=3; in words = 0x10..0x14)
REQ-031 Reset: rst_n low mid-stream with 3 in flight -> out_valid=0, err=0 at once; in_ready=1 after release; no stale output.
REQ-032 Streaming: sel=0..4 on consecutive cycles, out_ready=1 -> out 0x10..0x14 with out_sel 0..4, first at cycle 3, one per cycle.
REQ-033 Backpressure: out_ready=0 with sel=4,1,2,3 offered -> accepts 3 then in_ready=0; out holds 0x14; release -> 0x14,0x11,0x12,0x13 in order.
REQ-034 Bubbles: in_valid toggling 1,0,1 with out_ready random 50% -> scoreboard order and data match, no drops.
REQ-035 Out-of-range: sel=6 -> with macro, no output, err=1 next edge and sticky; without macro, out=0x00, out_sel=6, err=0.
REQ-036 Parameter sweep: INPUT_COUNT in {2,3,8,17}, RADIX in {2,4} -> latency equals STAGES, all sel values correct.
